// File: rtl/rcc_cfg_switch_ctrl.sv
// rcc_cfg_switch_ctrl
// -------------------
// Sequencer that owns the raw/test select (atspeed_mode) of the RCC
// configuration mux. A select change or a functional config update is only
// applied while the downstream kernel/bus clocks are gated:
//   IDLE -> GATE -> SWITCH -> SETTLE -> WAIT_RDY -> UNGATE -> IDLE
//
// Ports:
//   clk          RCC control clock
//   rst_n        synchronous reset, active low
//   atspeed_req  level, requested select (1 = test config set)
//   cfg_upd_req  single-cycle pulse, functional config registers changed
//   div_ready    all downstream dividers/switches stable
//   err_clr      single-cycle pulse, clears timeout_err
//   atspeed_mode registered select to the config mux
//   clk_en       downstream clock enable (0 = gated)
//   busy         high whenever the sequencer is not idle
//   switch_done  single-cycle pulse in the last gated cycle of a sequence
//   timeout_err  sticky, div_ready wait timed out
module rcc_cfg_switch_ctrl #(
  parameter int unsigned GATE_CYC    = 4,
  parameter int unsigned SETTLE_CYC  = 8,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic atspeed_req,
  input  logic cfg_upd_req,
  input  logic div_ready,
  input  logic err_clr,
  output logic atspeed_mode,
  output logic clk_en,
  output logic busy,
  output logic switch_done,
  output logic timeout_err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE     = 3'd1,
    SWITCH   = 3'd2,
    SETTLE   = 3'd3,
    WAIT_RDY = 3'd4,
    UNGATE   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] GATE_LD    = CNT_W'(GATE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(SETTLE_CYC - 32'd1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYC - 32'd1);

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             target_r, target_s;
  logic             mode_r, mode_s;
  logic             pend_r, pend_s;
  logic             err_r, err_s;
  logic             tmo_s;
  logic             start_s;
  logic             clk_en_r, busy_r, done_r;

  // Next-state, counter, select and sticky-flag logic.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    target_s = target_r;
    mode_s   = mode_r;
    pend_s   = pend_r | cfg_upd_req;
    tmo_s    = 1'b0;
    start_s  = (atspeed_req != mode_r) | pend_r | cfg_upd_req;

    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_s  = GATE;
          target_s = atspeed_req;
          cnt_s    = GATE_LD;
          // A request coinciding with the start is served by this sequence.
          pend_s   = 1'b0;
        end else begin
          state_s  = IDLE;
        end
      end
      GATE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = SWITCH;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      SWITCH: begin
        // For a pure config update the target equals the current mode.
        state_s = SETTLE;
        mode_s  = target_r;
        cnt_s   = SETTLE_LD;
      end
      SETTLE: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = WAIT_RDY;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end
      WAIT_RDY: begin
        if (div_ready) begin
          state_s = UNGATE;
        end else if (cnt_r == TMO_LAST) begin
          state_s = UNGATE;
          tmo_s   = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      UNGATE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase

    // A new timeout wins over a simultaneous clear.
    if (tmo_s) begin
      err_s = 1'b1;
    end else if (err_clr) begin
      err_s = 1'b0;
    end else begin
      err_s = err_r;
    end
  end

  // State register plus Moore outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= CNT_ZERO;
      target_r <= 1'b0;
      mode_r   <= 1'b0;
      pend_r   <= 1'b0;
      err_r    <= 1'b0;
      clk_en_r <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      target_r <= target_s;
      mode_r   <= mode_s;
      pend_r   <= pend_s;
      err_r    <= err_s;
      clk_en_r <= (state_s == IDLE);
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == UNGATE);
    end
  end

  assign atspeed_mode = mode_r;
  assign clk_en       = clk_en_r;
  assign busy         = busy_r;
  assign switch_done  = done_r;
  assign timeout_err  = err_r;

endmodule

// File: tb/tb_rcc_cfg_switch_ctrl.sv
// Self-checking bench for rcc_cfg_switch_ctrl. The reference model tracks
// the position inside a gated sequence as a plain cycle index and derives
// every expected output from the timeline arithmetic of the sequence.
module tb_rcc_cfg_switch_ctrl;

  localparam int GATE_CYC    = 4;
  localparam int SETTLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 255;
  localparam int WS          = GATE_CYC + 1 + SETTLE_CYC;  // first wait cycle index

  logic clk = 1'b0;
  logic rst_n, atspeed_req, cfg_upd_req, div_ready, err_clr;
  logic atspeed_mode, clk_en, busy, switch_done, timeout_err;

  int vectors = 0;
  int miscompares = 0;
  int low_cnt = 0;
  int done_cnt = 0;

  // Reference model state
  bit m_busy, m_wdone, m_mode, m_tgt, m_err, m_pend;
  int m_t, m_wlen;

  rcc_cfg_switch_ctrl #(
    .GATE_CYC(GATE_CYC), .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .atspeed_req(atspeed_req), .cfg_upd_req(cfg_upd_req),
    .div_ready(div_ready), .err_clr(err_clr), .atspeed_mode(atspeed_mode),
    .clk_en(clk_en), .busy(busy), .switch_done(switch_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic cmp_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented at it.
  task automatic model_step();
    bit set_e;
    int k;
    set_e = 1'b0;
    if (!rst_n) begin
      m_busy = 0; m_wdone = 0; m_mode = 0; m_tgt = 0; m_err = 0; m_pend = 0;
      m_t = 0; m_wlen = 0;
    end else begin
      if (!m_busy) begin
        if ((atspeed_req != m_mode) || m_pend || cfg_upd_req) begin
          m_busy = 1; m_t = 0; m_wdone = 0; m_tgt = atspeed_req; m_pend = 0;
        end
      end else begin
        if (cfg_upd_req) m_pend = 1;
        if (m_wdone && m_t == WS + m_wlen) begin
          m_busy = 0;
        end else begin
          if (m_t == GATE_CYC) m_mode = m_tgt;
          if (m_t >= WS && !m_wdone) begin
            k = m_t - WS;
            if (div_ready) begin
              m_wdone = 1; m_wlen = k + 1;
            end else if (k == TIMEOUT_CYC - 1) begin
              m_wdone = 1; m_wlen = TIMEOUT_CYC; set_e = 1;
            end
          end
          m_t++;
        end
      end
      if (set_e) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic cycle();
    bit exp_done;
    @(posedge clk);
    model_step();
    @(negedge clk);
    exp_done = m_busy && m_wdone && (m_t == WS + m_wlen);
    cmp("clk_en", clk_en, !m_busy);
    cmp("busy", busy, m_busy);
    cmp("switch_done", switch_done, exp_done);
    cmp("atspeed_mode", atspeed_mode, m_mode);
    cmp("timeout_err", timeout_err, m_err);
    if (clk_en === 1'b0) low_cnt++;
    if (switch_done === 1'b1) done_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0; atspeed_req = 1'b0; cfg_upd_req = 1'b0; div_ready = 1'b1; err_clr = 1'b0;
    run(3);
    cmp("reset_clk_en", clk_en, 1'b1);
    cmp("reset_mode", atspeed_mode, 1'b0);
    rst_n = 1'b1;
    run(2);

    // 0->1 switch with div_ready high: 15 gated cycles
    low_cnt = 0; done_cnt = 0;
    atspeed_req = 1'b1;
    run(5);
    cmp("mode_before_switch", atspeed_mode, 1'b0);
    cycle();
    cmp("mode_6th_low_cycle", atspeed_mode, 1'b1);
    run(16);
    cmp_int("low_0to1", low_cnt, 15);
    cmp_int("done_0to1", done_cnt, 1);

    // Back to raw, then a pure config update
    atspeed_req = 1'b0;
    run(20);
    low_cnt = 0; done_cnt = 0;
    cfg_upd_req = 1'b1;
    cycle();
    cfg_upd_req = 1'b0;
    run(20);
    cmp_int("low_cfg_upd", low_cnt, 15);
    cmp_int("done_cfg_upd", done_cnt, 1);
    cmp("mode_cfg_upd", atspeed_mode, 1'b0);

    // Timeout: div_ready held low
    low_cnt = 0;
    div_ready = 1'b0;
    atspeed_req = 1'b1;
    run(275);
    cmp_int("low_timeout", low_cnt, GATE_CYC + 1 + SETTLE_CYC + TIMEOUT_CYC + 1);
    cmp("err_sticky", timeout_err, 1'b1);
    run(3);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    cmp("err_cleared", timeout_err, 1'b0);

    // Second timeout with err_clr in the very cycle the timeout fires
    atspeed_req = 1'b0;
    for (int i = 0; i < 275; i++) begin
      err_clr = m_busy && !m_wdone && (m_t == WS + TIMEOUT_CYC - 1);
      cycle();
    end
    err_clr = 1'b0;
    cmp("err_set_wins", timeout_err, 1'b1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    div_ready = 1'b1;
    run(3);

    // Request toggled during GATE plus config update during SETTLE
    low_cnt = 0; done_cnt = 0;
    atspeed_req = 1'b1;
    cycle();
    atspeed_req = 1'b0;
    run(6);
    cfg_upd_req = 1'b1;
    cycle();
    cfg_upd_req = 1'b0;
    run(40);
    cmp_int("done_two_seq", done_cnt, 2);
    cmp_int("low_two_seq", low_cnt, 30);
    cmp("mode_two_seq", atspeed_mode, 1'b0);

    // Reset during SETTLE after the select moved to 1
    atspeed_req = 1'b1;
    run(9);
    cmp("mode_before_rst", atspeed_mode, 1'b1);
    rst_n = 1'b0; atspeed_req = 1'b0;
    done_cnt = 0;
    cycle();
    cmp("rst_mid_mode", atspeed_mode, 1'b0);
    cmp("rst_mid_clk_en", clk_en, 1'b1);
    cmp("rst_mid_busy", busy, 1'b0);
    cmp("rst_mid_err", timeout_err, 1'b0);
    rst_n = 1'b1;
    run(20);
    cmp_int("rst_mid_no_done", done_cnt, 0);

    // div_ready rising on the 3rd wait cycle
    low_cnt = 0;
    div_ready = 1'b0;
    atspeed_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      div_ready = m_busy && (m_t >= WS + 2);
      cycle();
    end
    div_ready = 1'b1;
    cmp_int("low_ready_3rd", low_cnt, 17);
    cmp("err_ready_3rd", timeout_err, 1'b0);

    // Randomized traffic
    for (int seg = 0; seg < 12; seg++) begin
      int rdy_pct;
      rdy_pct = (seg % 3 == 0) ? 2 : 60;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(63, 0) == 0) atspeed_req = ~atspeed_req;
        cfg_upd_req = ($urandom_range(19, 0) == 0);
        div_ready   = ($urandom_range(99, 0) < rdy_pct);
        err_clr     = ($urandom_range(39, 0) == 0);
        rst_n       = ($urandom_range(499, 0) != 0);
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
